ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-requester arbiter in front of one `ram_singleport` instance inside the MMU. It accepts read and write requests from port A (instruction side) and port B (data side). It issues at most one RAM operation per cycle under round-robin priority with an optional lock for read-modify-write sequences. It returns read data to the originating port with fixed one-cycle latency.

## Interface
Parameters:
- `WIDTH`, 10, RAM word-address width; must match the RAM instance.

Ports:
- `CLK` input 1: single clock; all state updates on the rising edge.
- `RST` input 1: reset, asynchronous and active-high.
- `A_REQ` / `B_REQ` input 1: request valid; held until granted.
- `A_WE` / `B_WE` input 1: 1 = write, 0 = read.
- `A_LOCK` / `B_LOCK` input 1: keep ownership for the following cycle after this grant.
- `A_ADDR` / `B_ADDR` input WIDTH: word address.
- `A_WDATA` / `B_WDATA` input 32: write data.
- `A_GNT` / `B_GNT` output 1: request accepted this cycle (REQ & GNT = transfer).
- `A_RVALID` / `B_RVALID` output 1: read data valid this cycle.
- `A_RDATA` / `B_RDATA` output 32: read data; zero when the matching RVALID is low.
- `RAM_RDEN`, `RAM_RADDR[WIDTH]`, `RAM_WREN`, `RAM_WADDR[WIDTH]`, `RAM_WDATA[32]` output: RAM drive.
- `RAM_RDATA` input 32: RAM read data.

## Operation
- Exactly one of {read, write, idle} is issued per cycle. Read and write are never issued together, because the RAM's read path returns the previous cycle's write data whenever a write occurred.
- Grant (combinational, same cycle):
  - If `lock_owner` is valid and that port requests, it wins.
  - Otherwise, if both ports request, the port not equal to `last` wins.
  - Otherwise, the single requester wins.
- The winner's GNT = 1; the loser's GNT = 0.
- On a granted write: `RAM_WREN` = 1, `RAM_WADDR`/`RAM_WDATA` = winner's ADDR/WDATA, `RAM_RDEN` = 0.
- On a granted read: `RAM_RDEN` = 1, `RAM_RADDR` = winner's ADDR, `RAM_WREN` = 0.
- When idle, all RAM enables are 0 and addresses/data are 0.
- Registered state:
  - `last`: updated to the winner on every grant.
  - `lock_owner`: set to the winner if its LOCK = 1 at grant; cleared on any grant with LOCK = 0, or in a cycle where the owner does not request.
  - `rsp_valid` and `rsp_port`: set on a granted read; cleared otherwise.
- Response routing: `X_RVALID` = `rsp_valid` & (`rsp_port` == X); `X_RDATA` = `RAM_RDATA` when valid, else 0.
- While `RST` = 1: all GNT = 0, all RAM enables = 0.
- Reset values:
  - `last` = B, so A has first priority.
  - `lock_owner` = none.
  - `rsp_valid` = 0.
- Reset mid-operation: an in-flight read response is dropped (no RVALID after reset); the lock is released.

## Timing
- Read issued in cycle t → `X_RVALID` and `X_RDATA` in cycle t+1. Back-to-back reads give one response per cycle.
- Write granted in cycle t is visible to a read granted in cycle t+1 or later.
- Fairness: with both ports continuously requesting and no lock, grants alternate A, B, A, B, …
- With a lock held, the owner may hold the RAM indefinitely; the other port waits. The lock is software-bounded to RMW pairs.
- A read-then-write RMW under lock: read in cycle t, data in cycle t+1, write may be requested and granted in cycle t+1.
- A requester's REQ/WE/ADDR/WDATA must stay stable from assertion until GNT.

## Structure
- Shared header `mmu_defs.vh`:
  - `PORT_A` = 1'b0, `PORT_B` = 1'b1.
  - `LOCK_NONE` encoding (2-bit lock field: valid + port).
- One sub-module `arb_rr2`: a combinational 2-way round-robin/lock grant from {req_a, req_b, last, lock_owner}, producing {gnt_a, gnt_b}. Registers live in `ram_arbiter`.
- Instantiate `ram_singleport` only in the enclosing MMU, not in this block.

## Test plan
- After reset, A writes 0xDEADBEEF to address 5, then A reads address 5 → A_GNT = 1 in both cycles; `A_RVALID` = 1 with `A_RDATA` = 0xDEADBEEF in the cycle after the read grant; B_RVALID = 0 throughout.
- A and B both read every cycle for 6 cycles from the first cycle after reset → grants A, B, A, B, A, B; RVALIDs alternate one cycle later, each with correct per-address data.
- B asserts LOCK on a read of address 3 (value 7) while A requests continuously → B reads 7, then B writes 8 with GNT in the next cycle; A_GNT = 0 during both; A is granted on the following cycle and reads 8.
- Write to address 1 in cycle t and read of address 2 in cycle t+1 (from the other port) → returned data equals the contents of address 2, not the write data (no forwarding leak).
- Assert `RST` in the cycle after a read grant → no RVALID asserted; after release, A has priority and the lock is clear.
- Single requester B idles with REQ = 0 → all RAM enables = 0 and RAM address/data outputs = 0.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared port encodings and lock-field type for the MMU RAM arbiter.
package ram_arbiter_pkg;

  localparam int DATA_W = 32;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;

  typedef struct packed {
    logic  valid;
    port_t port;
  } lock_t;

  localparam lock_t LOCK_NONE = '{valid: 1'b0, port: PORT_A};

  // Lock state that follows a grant to `owner` with its LOCK input `lock`.
  function automatic lock_t lock_after_grant(input port_t owner, input logic lock);
    lock_t next;
    next.valid = lock;
    next.port  = lock ? owner : PORT_A;
    return next;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// One requester port of the RAM arbiter: request/write payload in, grant and read response out.
interface ram_arbiter_if
  import ram_arbiter_pkg::*;
#(
  parameter int WIDTH = 10
);

  logic              req;
  logic              we;
  logic              lock;
  logic [WIDTH-1:0]  addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, lock, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, lock, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/ram_arbiter_arb_rr2.sv
// Combinational two-way grant: lock owner first, then round-robin against the last winner.
module arb_rr2
  import ram_arbiter_pkg::*;
(
  input  logic  req_a,
  input  logic  req_b,
  input  port_t last,
  input  lock_t lock_owner,
  output logic  gnt_a,
  output logic  gnt_b
);

  logic lock_a;
  logic lock_b;

  assign lock_a = lock_owner.valid && (lock_owner.port == PORT_A);
  assign lock_b = lock_owner.valid && (lock_owner.port == PORT_B);

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (lock_a && req_a) begin
      gnt_a = 1'b1;
    end else if (lock_b && req_b) begin
      gnt_b = 1'b1;
    end else if (req_a && req_b) begin
      // Contention without a usable lock goes to whoever did not win last.
      if (last == PORT_A) begin
        gnt_b = 1'b1;
      end else begin
        gnt_a = 1'b1;
      end
    end else if (req_a) begin
      gnt_a = 1'b1;
    end else if (req_b) begin
      gnt_b = 1'b1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port RAM: one read or write per cycle,
// round-robin with RMW lock, read data routed back to the issuing port one cycle later.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic              clk,
  input  logic              rst,
  ram_arbiter_if.slave      a,
  ram_arbiter_if.slave      b,
  output logic              ram_rden,
  output logic [WIDTH-1:0]  ram_raddr,
  output logic              ram_wren,
  output logic [WIDTH-1:0]  ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  port_t             last;
  lock_t             lock_owner;
  logic              rsp_valid;
  port_t             rsp_port;

  logic              arb_gnt_a;
  logic              arb_gnt_b;
  logic              grant_a;
  logic              grant_b;
  logic              any_gnt;
  port_t             winner;
  logic              win_we;
  logic              win_lock;
  logic [WIDTH-1:0]  win_addr;
  logic [DATA_W-1:0] win_wdata;

  arb_rr2 u_arb (
    .req_a      (a.req),
    .req_b      (b.req),
    .last       (last),
    .lock_owner (lock_owner),
    .gnt_a      (arb_gnt_a),
    .gnt_b      (arb_gnt_b)
  );

  // Nothing is granted while reset is held, so the RAM sees no enables either.
  assign grant_a = arb_gnt_a && !rst;
  assign grant_b = arb_gnt_b && !rst;
  assign any_gnt = grant_a || grant_b;

  assign a.gnt = grant_a;
  assign b.gnt = grant_b;

  always_comb begin
    winner    = PORT_A;
    win_we    = a.we;
    win_lock  = a.lock;
    win_addr  = a.addr;
    win_wdata = a.wdata;
    if (grant_b) begin
      winner    = PORT_B;
      win_we    = b.we;
      win_lock  = b.lock;
      win_addr  = b.addr;
      win_wdata = b.wdata;
    end
  end

  // Reads and writes are never issued together: the RAM would return write data on the read path.
  always_comb begin
    ram_rden  = 1'b0;
    ram_raddr = '0;
    ram_wren  = 1'b0;
    ram_waddr = '0;
    ram_wdata = '0;
    if (any_gnt) begin
      if (win_we) begin
        ram_wren  = 1'b1;
        ram_waddr = win_addr;
        ram_wdata = win_wdata;
      end else begin
        ram_rden  = 1'b1;
        ram_raddr = win_addr;
      end
    end
  end

  // A cycle with no grant means the lock owner stopped requesting, so the lock drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last       <= PORT_B;
      lock_owner <= LOCK_NONE;
      rsp_valid  <= 1'b0;
      rsp_port   <= PORT_A;
    end else begin
      if (any_gnt) begin
        last       <= winner;
        lock_owner <= lock_after_grant(winner, win_lock);
      end else begin
        lock_owner <= LOCK_NONE;
      end
      rsp_valid <= any_gnt && !win_we;
      rsp_port  <= winner;
    end
  end

  assign a.rvalid = rsp_valid && (rsp_port == PORT_A);
  assign b.rvalid = rsp_valid && (rsp_port == PORT_B);
  assign a.rdata  = a.rvalid ? ram_rdata : '0;
  assign b.rdata  = b.rvalid ? ram_rdata : '0;

  assert property (@(posedge clk) disable iff (rst) !(ram_rden && ram_wren));
  assert property (@(posedge clk) disable iff (rst) !(grant_a && grant_b));

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural single-port RAM and a read-response scoreboard.
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  localparam int WIDTH = 10;

  typedef struct {
    logic [31:0] data;
    int          due;
  } rsp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ram_rden;
  logic [WIDTH-1:0]  ram_raddr;
  logic              ram_wren;
  logic [WIDTH-1:0]  ram_waddr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata = '0;
  logic [31:0]       mem [0:(1<<WIDTH)-1];

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  rsp_t exp_a[$];
  rsp_t exp_b[$];

  ram_arbiter_if #(.WIDTH(WIDTH)) a_if ();
  ram_arbiter_if #(.WIDTH(WIDTH)) b_if ();

  ram_arbiter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a_if),
    .b         (b_if),
    .ram_rden  (ram_rden),
    .ram_raddr (ram_raddr),
    .ram_wren  (ram_wren),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Behavioural RAM: synchronous write, registered read, preloaded with 0xC0DE0000 + address.
  always @(posedge clk) begin
    if (ram_wren) mem[ram_waddr] = ram_wdata;
    if (ram_rden) ram_rdata <= mem[ram_raddr];
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Each expected response is due exactly one cycle after its read grant.
  always @(negedge clk) begin
    if (exp_a.size() != 0 && exp_a[0].due == cyc) begin
      check_output("a_rvalid", 32'(a_if.rvalid), 32'd1);
      check_output("a_rdata", a_if.rdata, exp_a[0].data);
      void'(exp_a.pop_front());
    end else if (a_if.rvalid) begin
      check_output("a_rvalid_unexpected", 32'(a_if.rvalid), 32'd0);
    end else begin
      check_output("a_rdata_idle", a_if.rdata, 32'd0);
    end
    if (exp_b.size() != 0 && exp_b[0].due == cyc) begin
      check_output("b_rvalid", 32'(b_if.rvalid), 32'd1);
      check_output("b_rdata", b_if.rdata, exp_b[0].data);
      void'(exp_b.pop_front());
    end else if (b_if.rvalid) begin
      check_output("b_rvalid_unexpected", 32'(b_if.rvalid), 32'd0);
    end else begin
      check_output("b_rdata_idle", b_if.rdata, 32'd0);
    end
  end

  task automatic expect_read(input port_t p, input logic [31:0] data);
    rsp_t r;
    r.data = data;
    r.due  = cyc + 1;
    if (p == PORT_A) exp_a.push_back(r);
    else exp_b.push_back(r);
  endtask

  task automatic set_a(input logic req, input logic we, input logic lock, input int addr, input logic [31:0] wdata);
    a_if.req   = req;
    a_if.we    = we;
    a_if.lock  = lock;
    a_if.addr  = WIDTH'(addr);
    a_if.wdata = wdata;
  endtask

  task automatic set_b(input logic req, input logic we, input logic lock, input int addr, input logic [31:0] wdata);
    b_if.req   = req;
    b_if.we    = we;
    b_if.lock  = lock;
    b_if.addr  = WIDTH'(addr);
    b_if.wdata = wdata;
  endtask

  task automatic check_grants(input logic exp_ga, input logic exp_gb, input string name);
    @(negedge clk);
    check_output({name, "_a_gnt"}, 32'(a_if.gnt), 32'(exp_ga));
    check_output({name, "_b_gnt"}, 32'(b_if.gnt), 32'(exp_gb));
  endtask

  task automatic check_ram(input logic rden, input int raddr, input logic wren, input int waddr,
                           input logic [31:0] wdata, input string name);
    check_output({name, "_rden"}, 32'(ram_rden), 32'(rden));
    check_output({name, "_raddr"}, 32'(ram_raddr), 32'(raddr));
    check_output({name, "_wren"}, 32'(ram_wren), 32'(wren));
    check_output({name, "_waddr"}, 32'(ram_waddr), 32'(waddr));
    check_output({name, "_wdata"}, ram_wdata, wdata);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus_reset();
    rst = 1'b1;
    set_a(1'b0, 1'b0, 1'b0, 0, 32'd0);
    set_b(1'b0, 1'b0, 1'b0, 0, 32'd0);
    check_grants(1'b0, 1'b0, "reset_pulse");
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < (1 << WIDTH); i++) mem[i] = 32'hC0DE_0000 + 32'(i);
    mem[3] = 32'd7;

    // Requests held during reset must not be granted or reach the RAM.
    set_a(1'b1, 1'b0, 1'b0, 5, 32'd0);
    set_b(1'b1, 1'b0, 1'b0, 6, 32'd0);
    check_grants(1'b0, 1'b0, "in_reset");
    check_ram(1'b0, 0, 1'b0, 0, 32'd0, "in_reset");
    next_cycle();
    rst = 1'b0;

    // A writes then reads back address 5.
    set_b(1'b0, 1'b0, 1'b0, 0, 32'd0);
    set_a(1'b1, 1'b1, 1'b0, 5, 32'hDEADBEEF);
    check_grants(1'b1, 1'b0, "a_write");
    check_ram(1'b0, 0, 1'b1, 5, 32'hDEADBEEF, "a_write");
    next_cycle();
    set_a(1'b1, 1'b0, 1'b0, 5, 32'd0);
    expect_read(PORT_A, 32'hDEADBEEF);
    check_grants(1'b1, 1'b0, "a_read");
    check_ram(1'b1, 5, 1'b0, 0, 32'd0, "a_read");
    next_cycle();
    set_a(1'b0, 1'b0, 1'b0, 0, 32'd0);
    check_grants(1'b0, 1'b0, "a_idle");
    next_cycle();

    // Both ports read every cycle from the first cycle after reset: grants alternate A, B.
    apply_stimulus_reset();
    for (int i = 0; i < 6; i++) begin
      set_a(1'b1, 1'b0, 1'b0, 10 + (i + 1) / 2, 32'd0);
      set_b(1'b1, 1'b0, 1'b0, 20 + i / 2, 32'd0);
      if (i % 2 == 0) expect_read(PORT_A, 32'hC0DE_0000 + 32'(10 + (i + 1) / 2));
      else expect_read(PORT_B, 32'hC0DE_0000 + 32'(20 + i / 2));
      check_grants(i % 2 == 0, i % 2 == 1, $sformatf("rr_%0d", i));
      next_cycle();
    end
    set_a(1'b0, 1'b0, 1'b0, 0, 32'd0);
    set_b(1'b0, 1'b0, 1'b0, 0, 32'd0);
    check_grants(1'b0, 1'b0, "rr_drain");
    next_cycle();

    // A alone reads address 4 so that B wins the next contention.
    set_a(1'b1, 1'b0, 1'b0, 4, 32'd0);
    expect_read(PORT_A, 32'hC0DE_0004);
    check_grants(1'b1, 1'b0, "pre_lock");
    next_cycle();

    // B locked RMW on address 3 while A keeps requesting a read of address 3.
    set_a(1'b1, 1'b0, 1'b0, 3, 32'd0);
    set_b(1'b1, 1'b0, 1'b1, 3, 32'd0);
    expect_read(PORT_B, 32'd7);
    check_grants(1'b0, 1'b1, "lock_read");
    next_cycle();
    set_b(1'b1, 1'b1, 1'b0, 3, 32'd8);
    check_grants(1'b0, 1'b1, "lock_write");
    check_ram(1'b0, 0, 1'b1, 3, 32'd8, "lock_write");
    next_cycle();
    set_b(1'b0, 1'b0, 1'b0, 0, 32'd0);
    expect_read(PORT_A, 32'd8);
    check_grants(1'b1, 1'b0, "after_lock");
    next_cycle();
    set_a(1'b0, 1'b0, 1'b0, 0, 32'd0);
    check_grants(1'b0, 1'b0, "lock_drain");
    next_cycle();

    // Write to address 1 followed by a read of address 2 must not leak the write data.
    set_a(1'b1, 1'b1, 1'b0, 1, 32'h1234_5678);
    check_grants(1'b1, 1'b0, "leak_write");
    next_cycle();
    set_a(1'b0, 1'b0, 1'b0, 0, 32'd0);
    set_b(1'b1, 1'b0, 1'b0, 2, 32'd0);
    expect_read(PORT_B, 32'hC0DE_0002);
    check_grants(1'b0, 1'b1, "leak_read");
    next_cycle();
    set_b(1'b0, 1'b0, 1'b0, 0, 32'd0);
    check_grants(1'b0, 1'b0, "leak_drain");
    next_cycle();

    // B locked read, then reset in the response cycle: response dropped, lock released.
    set_b(1'b1, 1'b0, 1'b1, 6, 32'd0);
    check_grants(1'b0, 1'b1, "pre_reset_read");
    next_cycle();
    rst = 1'b1;
    set_a(1'b1, 1'b0, 1'b0, 7, 32'd0);
    set_b(1'b1, 1'b0, 1'b0, 8, 32'd0);
    check_grants(1'b0, 1'b0, "mid_reset");
    check_output("mid_reset_b_rvalid", 32'(b_if.rvalid), 32'd0);
    check_ram(1'b0, 0, 1'b0, 0, 32'd0, "mid_reset");
    next_cycle();
    rst = 1'b0;
    expect_read(PORT_A, 32'hC0DE_0007);
    check_grants(1'b1, 1'b0, "post_reset_a");
    next_cycle();
    set_a(1'b0, 1'b0, 1'b0, 0, 32'd0);
    expect_read(PORT_B, 32'hC0DE_0008);
    check_grants(1'b0, 1'b1, "post_reset_b");
    next_cycle();
    set_b(1'b0, 1'b0, 1'b0, 0, 32'd0);
    check_grants(1'b0, 1'b0, "post_reset_drain");
    next_cycle();

    // Idle with non-zero payloads on both ports: RAM outputs stay at zero.
    set_a(1'b0, 1'b1, 1'b0, 9, 32'h0000_0055);
    set_b(1'b0, 1'b1, 1'b1, 17, 32'h0000_AAAA);
    check_grants(1'b0, 1'b0, "idle");
    check_ram(1'b0, 0, 1'b0, 0, 32'd0, "idle");
    next_cycle();
    next_cycle();

    check_output("a_queue_drained", 32'(exp_a.size()), 32'd0);
    check_output("b_queue_drained", 32'(exp_b.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
